// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/response bus between the MEM-stage LSU (master) and the data memory (slave).
interface mem_stage_lsu_if;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [63:0] dmem_req_addr;
    logic [63:0] dmem_req_wdata;
    logic [7:0]  dmem_req_be;
    logic        dmem_rsp_valid;
    logic [63:0] dmem_rsp_rdata;

    modport master (
        output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_be,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_be,
        output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: stalls the pipeline while one access runs on the data-memory bus.
// Define MEM_STAGE_LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module mem_stage_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_M,
    input  logic        MemWrite_M,
    input  logic [2:0]  Funct3_M,
    input  logic [63:0] ALUResult_M,
    input  logic [63:0] WriteData_M,
    output logic        Stall_M,
    output logic [63:0] ReadData_M,
    output logic        MisalignErr_M,
    mem_stage_lsu_if.master dmem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  be_q, be_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [2:0]  offset_q, offset_d;
    logic [63:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic        access_s;
    logic        mis_s;
    logic [2:0]  off_s;

    // Naturally-aligned offsets pass through untouched, so this is also safe in trap mode.
    function automatic logic [2:0] align_offset(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'b00:   return off;
            2'b01:   return {off[2:1], 1'b0};
            2'b10:   return {off[2], 2'b00};
            2'b11:   return 3'b000;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] byte_enables(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            2'b00:   base = 8'h01;
            2'b01:   base = 8'h03;
            2'b10:   base = 8'h0F;
            2'b11:   base = 8'hFF;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

`ifdef MEM_STAGE_LSU_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            2'b10:   return (off[1:0] != 2'b00);
            2'b11:   return (off != 3'b000);
            default: return 1'b0;
        endcase
    endfunction
`endif

    function automatic logic [63:0] extend_load(input logic [2:0] f3, input logic [63:0] s);
        case (f3)
            3'b000:  return {{56{s[7]}}, s[7:0]};
            3'b001:  return {{48{s[15]}}, s[15:0]};
            3'b010:  return {{32{s[31]}}, s[31:0]};
            3'b100:  return {56'd0, s[7:0]};
            3'b101:  return {48'd0, s[15:0]};
            3'b110:  return {32'd0, s[31:0]};
            default: return s;
        endcase
    endfunction

    // Next-state, request capture and stall decode.
    always_comb begin
        access_s = MemRead_M | MemWrite_M;
        off_s    = align_offset(Funct3_M[1:0], ALUResult_M[2:0]);
`ifdef MEM_STAGE_LSU_MISALIGN_TRAP_EN
        mis_s    = access_s & is_misaligned(Funct3_M[1:0], ALUResult_M[2:0]);
`else
        mis_s    = 1'b0;
`endif
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        funct3_d = funct3_q;
        offset_d = offset_q;
        rdata_d  = rdata_q;
        mis_d    = 1'b0;
        Stall_M  = 1'b0;
        case (state_q)
            IDLE: begin
                if (access_s && !mis_s) begin
                    Stall_M  = 1'b1;
                    we_d     = MemWrite_M;
                    addr_d   = {ALUResult_M[63:3], 3'b000};
                    wdata_d  = WriteData_M << {off_s, 3'b000};
                    be_d     = byte_enables(Funct3_M[1:0], off_s);
                    funct3_d = Funct3_M;
                    offset_d = off_s;
                    state_d  = REQ;
                end else if (mis_s) begin
                    mis_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                Stall_M = 1'b1;
                if (dmem.dmem_req_ready) begin
                    state_d = we_q ? DONE : WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                Stall_M = 1'b1;
                if (dmem.dmem_rsp_valid) begin
                    rdata_d = extend_load(funct3_q, dmem.dmem_rsp_rdata >> {offset_q, 3'b000});
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            // The completing instruction is still in M here, so its access is not re-issued.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request-field registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= 64'd0;
            wdata_q  <= 64'd0;
            be_q     <= 8'd0;
            funct3_q <= 3'd0;
            offset_q <= 3'd0;
            rdata_q  <= 64'd0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            funct3_q <= funct3_d;
            offset_q <= offset_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
        end
    end

    assign dmem.dmem_req_valid = (state_q == REQ);
    assign dmem.dmem_req_we    = we_q;
    assign dmem.dmem_req_addr  = addr_q;
    assign dmem.dmem_req_wdata = wdata_q;
    assign dmem.dmem_req_be    = be_q;
    assign ReadData_M          = rdata_q;
    assign MisalignErr_M       = mis_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: vector table of single accesses plus reset/misalign sequences.
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic        MemRead_M;
    logic        MemWrite_M;
    logic [2:0]  Funct3_M;
    logic [63:0] ALUResult_M;
    logic [63:0] WriteData_M;
    logic        Stall_M;
    logic [63:0] ReadData_M;
    logic        MisalignErr_M;

    int checks;
    int failures;

    mem_stage_lsu_if dmem_if ();

    mem_stage_lsu dut (
        .clk           (clk),
        .rst           (rst),
        .MemRead_M     (MemRead_M),
        .MemWrite_M    (MemWrite_M),
        .Funct3_M      (Funct3_M),
        .ALUResult_M   (ALUResult_M),
        .WriteData_M   (WriteData_M),
        .Stall_M       (Stall_M),
        .ReadData_M    (ReadData_M),
        .MisalignErr_M (MisalignErr_M),
        .dmem          (dmem_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          delay;
        logic [7:0]  exp_be;
        logic [63:0] exp_wdata;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%016h expected=0x%016h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int          stalls;
        int          exp_stalls;
        logic        ld;
        logic [63:0] ea;
        ld         = ~v.wr;
        ea         = {v.addr[63:3], 3'b000};
        exp_stalls = 2 + v.delay + (ld ? 1 : 0);
        MemRead_M   = v.rd;
        MemWrite_M  = v.wr;
        Funct3_M    = v.f3;
        ALUResult_M = v.addr;
        WriteData_M = v.wdata;
        dmem_if.dmem_rsp_rdata = v.rdata;
        #1;
        stalls = int'(Stall_M);
        step();
        for (int c = 0; c <= v.delay; c++) begin
            check({v.name, " req_valid"}, 64'(dmem_if.dmem_req_valid), 64'd1);
            check({v.name, " req_addr"}, dmem_if.dmem_req_addr, ea);
            check({v.name, " req_be"}, 64'(dmem_if.dmem_req_be), 64'(v.exp_be));
            check({v.name, " req_we"}, 64'(dmem_if.dmem_req_we), 64'(v.wr));
            if (!ld) check({v.name, " req_wdata"}, dmem_if.dmem_req_wdata, v.exp_wdata);
            stalls += int'(Stall_M);
            if (c == v.delay) dmem_if.dmem_req_ready = 1'b1;
            step();
        end
        dmem_if.dmem_req_ready = 1'b0;
        if (ld) begin
            check({v.name, " wait_valid"}, 64'(dmem_if.dmem_req_valid), 64'd0);
            stalls += int'(Stall_M);
            dmem_if.dmem_rsp_valid = 1'b1;
            step();
            dmem_if.dmem_rsp_valid = 1'b0;
        end
        check({v.name, " done_stall"}, 64'(Stall_M), 64'd0);
        check({v.name, " done_valid"}, 64'(dmem_if.dmem_req_valid), 64'd0);
        if (ld) check({v.name, " rdata"}, ReadData_M, v.exp_rdata);
        check({v.name, " misalign"}, 64'(MisalignErr_M), 64'd0);
        check({v.name, " stall_cycles"}, 64'(stalls), 64'(exp_stalls));
        MemRead_M  = 1'b0;
        MemWrite_M = 1'b0;
        step();
        check({v.name, " idle_stall"}, 64'(Stall_M), 64'd0);
        if (ld) check({v.name, " rdata_hold"}, ReadData_M, v.exp_rdata);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        vecs.push_back('{"SD",  1'b0, 1'b1, 3'b011, 64'h1000, 64'h1122334455667788, 64'h0, 0,
                         8'hFF, 64'h1122334455667788, 64'h0});
        vecs.push_back('{"LB",  1'b1, 1'b0, 3'b000, 64'h2005, 64'h0, 64'h000080FF00000000, 0,
                         8'h20, 64'h0, 64'hFFFFFFFFFFFFFF80});
        vecs.push_back('{"LBU", 1'b1, 1'b0, 3'b100, 64'h2005, 64'h0, 64'h000080FF00000000, 0,
                         8'h20, 64'h0, 64'h0000000000000080});
        vecs.push_back('{"SH",  1'b0, 1'b1, 3'b001, 64'h3006, 64'hABCD, 64'h0, 3,
                         8'hC0, 64'hABCD000000000000, 64'h0});
`ifndef MEM_STAGE_LSU_MISALIGN_TRAP_EN
        vecs.push_back('{"LW_mis", 1'b1, 1'b0, 3'b010, 64'h4002, 64'h0, 64'h0000000089ABCDEF, 0,
                         8'h0F, 64'h0, 64'hFFFFFFFF89ABCDEF});
`endif
        vecs.push_back('{"LD",  1'b1, 1'b0, 3'b011, 64'h5008, 64'h0, 64'hDEADBEEF01234567, 1,
                         8'hFF, 64'h0, 64'hDEADBEEF01234567});
        vecs.push_back('{"LHU", 1'b1, 1'b0, 3'b101, 64'h6006, 64'h0, 64'h8001000000000000, 0,
                         8'hC0, 64'h0, 64'h0000000000008001});
        vecs.push_back('{"SB",  1'b0, 1'b1, 3'b000, 64'h7003, 64'hA5, 64'h0, 0,
                         8'h08, 64'h00000000A5000000, 64'h0});
        vecs.push_back('{"SW",  1'b0, 1'b1, 3'b010, 64'h8004, 64'h12345678, 64'h0, 0,
                         8'hF0, 64'h1234567800000000, 64'h0});
        vecs.push_back('{"RW_both", 1'b1, 1'b1, 3'b011, 64'h9000, 64'h55, 64'h0, 0,
                         8'hFF, 64'h0000000000000055, 64'h0});
        vecs.push_back('{"LH",  1'b1, 1'b0, 3'b001, 64'hA002, 64'h0, 64'h00000000FEDC0000, 0,
                         8'h0C, 64'h0, 64'hFFFFFFFFFFFFFEDC});

        rst         = 1'b1;
        MemRead_M   = 1'b0;
        MemWrite_M  = 1'b0;
        Funct3_M    = 3'b000;
        ALUResult_M = 64'h0;
        WriteData_M = 64'h0;
        dmem_if.dmem_req_ready = 1'b0;
        dmem_if.dmem_rsp_valid = 1'b0;
        dmem_if.dmem_rsp_rdata = 64'h0;
        step();
        step();
        check("reset valid", 64'(dmem_if.dmem_req_valid), 64'd0);
        check("reset rdata", ReadData_M, 64'd0);
        check("reset misalign", 64'(MisalignErr_M), 64'd0);
        check("reset be", 64'(dmem_if.dmem_req_be), 64'd0);
        rst = 1'b0;
        step();
        check("post-reset stall", 64'(Stall_M), 64'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

`ifdef MEM_STAGE_LSU_MISALIGN_TRAP_EN
        MemRead_M   = 1'b1;
        Funct3_M    = 3'b010;
        ALUResult_M = 64'h4002;
        #1;
        check("LW_trap stall", 64'(Stall_M), 64'd0);
        check("LW_trap valid0", 64'(dmem_if.dmem_req_valid), 64'd0);
        step();
        check("LW_trap pulse", 64'(MisalignErr_M), 64'd1);
        check("LW_trap valid1", 64'(dmem_if.dmem_req_valid), 64'd0);
        MemRead_M = 1'b0;
        step();
        check("LW_trap pulse_end", 64'(MisalignErr_M), 64'd0);
        check("LW_trap valid2", 64'(dmem_if.dmem_req_valid), 64'd0);
`endif

        // Reset while waiting for a load response; ReadData_M is non-zero from LH beforehand.
        MemRead_M   = 1'b1;
        Funct3_M    = 3'b011;
        ALUResult_M = 64'h0100;
        #1;
        step();
        dmem_if.dmem_req_ready = 1'b1;
        step();
        dmem_if.dmem_req_ready = 1'b0;
        check("rstwait in_wait_valid", 64'(dmem_if.dmem_req_valid), 64'd0);
        check("rstwait in_wait_stall", 64'(Stall_M), 64'd1);
        MemRead_M = 1'b0;
        rst = 1'b1;
        #2;
        check("rstwait async_rdata", ReadData_M, 64'd0);
        check("rstwait async_stall", 64'(Stall_M), 64'd0);
        step();
        rst = 1'b0;
        dmem_if.dmem_rsp_valid = 1'b1;
        dmem_if.dmem_rsp_rdata = 64'hFFFFFFFFFFFFFFFF;
        step();
        dmem_if.dmem_rsp_valid = 1'b0;
        check("rstwait rsp_ignored", ReadData_M, 64'd0);
        check("rstwait stall", 64'(Stall_M), 64'd0);
        check("rstwait valid", 64'(dmem_if.dmem_req_valid), 64'd0);
        step();
        check("rstwait rdata_hold", ReadData_M, 64'd0);

        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
